// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues credit-limited memory requests from the PC
// and returns the responses in order through a small instruction queue toward decode.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              DEPTH      = 4,
  parameter int              MAX_OUTS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_ready_i
);

  localparam int QAW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTS + 1);
  localparam int TAW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [OW-1:0]   outs_reg, outs_next;
  logic [OW-1:0]   disc_reg, disc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [TAW-1:0]  tag_wr_reg, tag_wr_next;
  logic [TAW-1:0]  tag_rd_reg, tag_rd_next;
  logic [QAW-1:0]  q_wr_reg, q_wr_next;
  logic [QAW-1:0]  q_rd_reg, q_rd_next;

  logic [XLEN-1:0] tag_mem [MAX_OUTS];
  logic [XLEN-1:0] q_addr  [DEPTH];
  logic [XLEN-1:0] q_data  [DEPTH];

  logic credit_ok;
  logic grant;
  logic rsp_take;
  logic rsp_drop;
  logic deq;

  // Tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    return (p == TAW'(MAX_OUTS - 1)) ? '0 : p + TAW'(1);
  endfunction

  // Stale (discarded) responses still occupy memory slots, so they count against MAX_OUTS only.
  assign credit_ok = (int'(outs_reg) + int'(disc_reg) < MAX_OUTS) &&
                     (int'(count_reg) + int'(outs_reg) < DEPTH);

  assign mem_req_o    = rst && !jump_en_i && credit_ok;
  assign mem_addr_o   = pc_reg;
  assign grant        = mem_req_o && mem_gnt_i;
  assign rsp_drop     = mem_rvalid_i && (disc_reg != '0);
  assign rsp_take     = mem_rvalid_i && (disc_reg == '0) && !jump_en_i;

  assign inst_valid_o = (count_reg != '0) && !jump_en_i;
  assign deq          = inst_valid_o && inst_ready_i && !hold_flag_i;
  assign inst_o       = inst_valid_o ? q_data[q_rd_reg] : NOP;
  assign inst_addr_o  = inst_valid_o ? q_addr[q_rd_reg] : '0;

  always_comb begin
    pc_next     = pc_reg;
    outs_next   = outs_reg;
    disc_next   = disc_reg;
    count_next  = count_reg;
    tag_wr_next = tag_wr_reg;
    tag_rd_next = tag_rd_reg;
    q_wr_next   = q_wr_reg;
    q_rd_next   = q_rd_reg;
    if (jump_en_i) begin
      // A response landing in the redirect cycle is already stale: it is both counted and dropped.
      pc_next     = jump_addr_i & ~XLEN'(3);
      outs_next   = '0;
      disc_next   = disc_reg + outs_reg - OW'(mem_rvalid_i);
      count_next  = '0;
      tag_wr_next = '0;
      tag_rd_next = '0;
      q_wr_next   = '0;
      q_rd_next   = '0;
    end else begin
      if (grant) begin
        pc_next     = pc_reg + XLEN'(4);
        tag_wr_next = tag_inc(tag_wr_reg);
      end
      if (rsp_take) begin
        tag_rd_next = tag_inc(tag_rd_reg);
        q_wr_next   = q_wr_reg + QAW'(1);
      end
      if (deq) begin
        q_rd_next = q_rd_reg + QAW'(1);
      end
      outs_next  = outs_reg + OW'(grant) - OW'(rsp_take);
      disc_next  = disc_reg - OW'(rsp_drop);
      count_next = count_reg + CW'(rsp_take) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg     <= RESET_ADDR;
      outs_reg   <= '0;
      disc_reg   <= '0;
      count_reg  <= '0;
      tag_wr_reg <= '0;
      tag_rd_reg <= '0;
      q_wr_reg   <= '0;
      q_rd_reg   <= '0;
    end else begin
      pc_reg     <= pc_next;
      outs_reg   <= outs_next;
      disc_reg   <= disc_next;
      count_reg  <= count_next;
      tag_wr_reg <= tag_wr_next;
      tag_rd_reg <= tag_rd_next;
      q_wr_reg   <= q_wr_next;
      q_rd_reg   <= q_rd_next;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the counters and pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[tag_wr_reg] <= pc_reg;
    end
    if (rsp_take) begin
      q_addr[q_wr_reg] <= tag_mem[tag_rd_reg];
      q_data[q_wr_reg] <= mem_rdata_i;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!(rsp_take && !deq && count_reg == CW'(DEPTH)));
      assert (!(mem_rvalid_i && outs_reg == '0 && disc_reg == '0));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: variable-latency memory model plus an in-order scoreboard of expected fetches.
module tb_fetch_queue;

  localparam int          DEPTH      = 4;
  localparam int          MAX_OUTS   = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        hold = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_ready = 1'b1;

  fetch_queue #(
    .XLEN(32), .RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_flag_i(hold),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr),
    .inst_ready_i(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_rand = 1'b0;
  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fetch_pc = RESET_ADDR;
  int          deq_count = 0;
  int          grant_count = 0;
  logic [31:0] last_deq_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Memory: responses in request order, at least one cycle after grant, one per cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_gnt    = gnt_rand ? ($urandom_range(3) != 0) : 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (!rst) begin
        pend_q.delete();
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  // Monitor: sampled mid-cycle, so values are those the DUT sees at the next rising edge.
  initial begin
    int          d;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs: req=%b valid=%b inst=%h addr=%h, required 0 0 %h 0",
                   mem_req, inst_valid, inst, inst_addr, NOP);
        end
        exp_q.delete();
        pend_q.delete();
        fetch_pc = RESET_ADDR;
      end else if (jump_en) begin
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL jump_quiet: req=%b valid=%b, required 0 0", mem_req, inst_valid);
        end
        exp_q.delete();
        fetch_pc = jump_addr & ~32'h3;
      end else begin
        if (mem_req === 1'b1 && mem_gnt) begin
          checks++;
          if (mem_addr !== fetch_pc) begin
            errors++;
            $display("FAIL fetch_addr: got %h, required %h", mem_addr, fetch_pc);
          end
          d = cyc + lat;
          if (pend_q.size() > 0 && pend_q[pend_q.size()-1].due >= d)
            d = pend_q[pend_q.size()-1].due + 1;
          pend_q.push_back('{addr: mem_addr, due: d});
          exp_q.push_back(fetch_pc);
          fetch_pc += 32'd4;
          grant_count++;
          checks++;
          if (pend_q.size() > MAX_OUTS || exp_q.size() > DEPTH) begin
            errors++;
            $display("FAIL credit: in_flight=%0d queued_or_pending=%0d, required <=%0d and <=%0d",
                     pend_q.size(), exp_q.size(), MAX_OUTS, DEPTH);
          end
        end
        if (inst_valid === 1'b1 && inst_ready && !hold) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_inst: got addr %h, required no instruction", inst_addr);
          end else begin
            e = exp_q.pop_front();
            if (inst_addr !== e || inst !== mem_word(e)) begin
              errors++;
              $display("FAIL inst_out: got %h/%h, required %h/%h", inst_addr, inst, e, mem_word(e));
            end
          end
          deq_count++;
          last_deq_addr = inst_addr;
        end else if (inst_valid !== 1'b1) begin
          checks++;
          if (inst !== NOP || inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: got %h/%h, required %h/0", inst, inst_addr, NOP);
          end
        end
      end
    end
  end

  task automatic wait_deq(input int target, input string name);
    int n = 0;
    while (deq_count < target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (deq_count < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: dequeues %0d, required %0d", name, deq_count, target);
    end
  endtask

  task automatic wait_pending2(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #2;
      if (pend_q.size() == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_pending: in flight %0d, required 2", name, pend_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: req=%b valid=%b, required 0 0", mem_req, inst_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    deq_count = 0;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (deq_count != 10) begin
      errors++;
      $display("FAIL stream_rate: dequeues %0d, required 10", deq_count);
    end
    checks++;
    if (last_deq_addr !== 32'h24) begin
      errors++;
      $display("FAIL stream_last: addr %h, required 00000024", last_deq_addr);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #3;
    rst = 1'b0;
    inst_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    grant_count = 0;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (grant_count != DEPTH || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL full_stop: grants %0d req=%b, required %0d 0", grant_count, mem_req, DEPTH);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_addr !== RESET_ADDR) begin
      errors++;
      $display("FAIL full_head: valid=%b addr=%h, required 1 %h", inst_valid, inst_addr, RESET_ADDR);
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    deq_count = 0;
    repeat (16) @(negedge clk);
    #1;
    checks++;
    if (deq_count < 12) begin
      errors++;
      $display("FAIL drain_rate: dequeues %0d, required >=12", deq_count);
    end
  endtask

  task automatic test_jump_stale();
    int base;
    @(posedge clk);
    #1;
    lat = 3;
    wait_pending2("jump_stale");
    jump_en = 1'b1;
    jump_addr = 32'h0000_0100;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    base = deq_count;
    wait_deq(base + 1, "jump_first");
    checks++;
    if (last_deq_addr !== 32'h100) begin
      errors++;
      $display("FAIL jump_first: addr %h, required 00000100", last_deq_addr);
    end
    wait_deq(base + 2, "jump_second");
    checks++;
    if (last_deq_addr !== 32'h104) begin
      errors++;
      $display("FAIL jump_second: addr %h, required 00000104", last_deq_addr);
    end
  endtask

  task automatic test_jump_rvalid();
    int  base;
    bit  found = 1'b0;
    @(posedge clk);
    #1;
    lat = 1;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #2;
      if (mem_rvalid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL jrv_rvalid: no response seen, required one");
    end
    jump_en = 1'b1;
    jump_addr = 32'h0000_0103;
    base = deq_count;
    @(negedge clk);
    #1;
    checks++;
    if (inst_valid !== 1'b0 || deq_count != base) begin
      errors++;
      $display("FAIL jrv_no_deq: valid=%b dequeues %0d, required 0 %0d", inst_valid, deq_count, base);
    end
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL jrv_align: mem_addr %h, required 00000100", mem_addr);
    end
    base = deq_count;
    wait_deq(base + 1, "jrv_first");
    checks++;
    if (last_deq_addr !== 32'h100) begin
      errors++;
      $display("FAIL jrv_first: addr %h, required 00000100", last_deq_addr);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    @(posedge clk);
    #1;
    lat = 1;
    jump_en = 1'b1;
    jump_addr = 32'h0000_0020;
    hold = 1'b1;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    @(negedge clk);
    #1;
    while (inst_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h20) begin
        errors++;
        $display("FAIL hold_head: cycle %0d valid=%b addr=%h, required 1 00000020", i, inst_valid, inst_addr);
      end
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_credit: req=%b, required 0", mem_req);
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (inst_addr !== 32'h20) begin
      errors++;
      $display("FAIL hold_release: addr %h, required 00000020", inst_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h24) begin
      errors++;
      $display("FAIL hold_next: valid=%b addr=%h, required 1 00000024", inst_valid, inst_addr);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    @(posedge clk);
    #1;
    lat = 3;
    repeat (5) @(posedge clk);
    #1;
    jump_en = 1'b1;
    jump_addr = 32'h0000_0200;
    @(posedge clk);
    #1;
    jump_addr = 32'hFFFF_FFFA;
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    base = deq_count;
    wait_deq(base + 1, "b2b_first");
    checks++;
    if (last_deq_addr !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL b2b_first: addr %h, required fffffff8", last_deq_addr);
    end
    wait_deq(base + 3, "b2b_wrap");
    checks++;
    if (last_deq_addr !== 32'h0) begin
      errors++;
      $display("FAIL b2b_wrap: addr %h, required 00000000", last_deq_addr);
    end
  endtask

  task automatic test_reset_midburst();
    int base;
    @(posedge clk);
    #1;
    lat = 3;
    wait_pending2("rst_mid");
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b valid=%b inst=%h addr=%h, required 0 0 %h 0",
               mem_req, inst_valid, inst, inst_addr, NOP);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    base = deq_count;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_ADDR) begin
      errors++;
      $display("FAIL restart_fetch: req=%b addr=%h, required 1 %h", mem_req, mem_addr, RESET_ADDR);
    end
    wait_deq(base + 1, "restart_first");
    checks++;
    if (last_deq_addr !== RESET_ADDR) begin
      errors++;
      $display("FAIL restart_first: addr %h, required %h", last_deq_addr, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    int base;
    gnt_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      inst_ready = ($urandom_range(3) != 0);
      hold       = ($urandom_range(7) == 0);
      lat        = $urandom_range(4, 1);
      jump_en    = ($urandom_range(19) == 0);
      jump_addr  = $urandom();
    end
    @(posedge clk);
    #1;
    gnt_rand   = 1'b0;
    jump_en    = 1'b0;
    hold       = 1'b0;
    inst_ready = 1'b1;
    base = deq_count;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (deq_count <= base) begin
      errors++;
      $display("FAIL random_progress: dequeues %0d, required >%0d", deq_count, base);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_backpressure();
    test_jump_stale();
    test_jump_rvalid();
    test_hold();
    test_back_to_back();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
